// File: rtl/mmu_pkg.sv
// mmu_pkg
//   Shared definitions for the TLB refill path: walker state encoding,
//   EntryLo/PTE field positions, the unmapped-segment code and the VPN2
//   slice of a virtual address, plus the page-table address helper.
package mmu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_EVEN = 3'd1,
    ST_RD_ODD  = 3'd2,
    ST_WRITE   = 3'd3,
    ST_FAULT   = 3'd4
  } walk_state_e;

  // EntryLo / PTE layout (identical formats)
  localparam int PFN_HI = 25;
  localparam int PFN_LO = 6;
  localparam int D_BIT  = 2;
  localparam int V_BIT  = 1;

  // vaddr[31:30] value of the unmapped kernel segment
  localparam logic [1:0] KSEG_UNMAPPED = 2'b10;

  // VPN2 slice and the bit that picks the odd page of the pair
  localparam int VPN2_HI     = 31;
  localparam int VPN2_LO     = 13;
  localparam int VPN2_W      = VPN2_HI - VPN2_LO + 1;
  localparam int ODD_SEL_BIT = 12;

  // Address of the even PTE of a pair: each pair is 8 bytes, indexed by VPN2.
  // The sum wraps modulo 2^32.
  function automatic logic [31:0] pte_pair_addr(input logic [31:0]       base,
                                                input logic [VPN2_W-1:0] vpn2);
    return base + {{(32 - VPN2_W - 3){1'b0}}, vpn2, 3'b000};
  endfunction

endpackage

// File: rtl/tlb_victim_ctr.sv
// tlb_victim_ctr
//   Free-running replacement-victim counter. Advances every clock and wraps
//   from ENTRIES-1 back to WIRED, so wired entries are never offered.
// Ports:
//   clock    in   system clock
//   reset    in   synchronous, active-low reset (counter -> WIRED)
//   o_victim out  current victim index
module tlb_victim_ctr #(
  parameter int ENTRIES = 16,
  parameter int WIRED   = 0,
  parameter int IDX_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  output logic [IDX_W-1:0] o_victim
);

  logic [IDX_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (!reset)
      r_cnt <= IDX_W'(WIRED);
    else if (r_cnt == IDX_W'(ENTRIES - 1))
      r_cnt <= IDX_W'(WIRED);
    else
      r_cnt <= r_cnt + IDX_W'(1);
  end

  assign o_victim = r_cnt;

endmodule

// File: rtl/tlb_refill_walker.sv
// tlb_refill_walker
//   Hardware TLB refill engine. On an accepted miss it reads the even/odd
//   PTE pair from a linear page table, then writes EntryHi/EntryLo0/EntryLo1
//   into the TLB at a victim index, or reports a fault when the address is
//   in the unmapped segment or the selected PTE is invalid.
// Ports:
//   clock, reset                      clock; synchronous active-low reset
//   miss_valid/miss_vaddr/miss_ready  miss handshake (ready only when idle)
//   ptbase                            page-table base (8-byte aligned)
//   mem_req/mem_addr/mem_ack/mem_rdata  single-beat read port
//   tlb_we/tlb_index/tlb_entry_hi/lo0/lo1  TLB write port
//   done/fault                        walk-complete pulse, fault qualifier
// Optional feature (macro TLB_WALK_STATS_EN):
//   adds walk_count/fault_count saturating statistics outputs.
module tlb_refill_walker
  import mmu_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int WIRED   = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        miss_valid,
  input  logic [31:0] miss_vaddr,
  output logic        miss_ready,
  input  logic [31:0] ptbase,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        tlb_we,
  output logic [31:0] tlb_index,
  output logic [31:0] tlb_entry_hi,
  output logic [31:0] tlb_entry_lo0,
  output logic [31:0] tlb_entry_lo1,
  output logic        done,
  output logic        fault
`ifdef TLB_WALK_STATS_EN
  ,
  output logic [31:0] walk_count,
  output logic [31:0] fault_count
`endif
);

  walk_state_e       r_state;
  walk_state_e       w_next;
  logic [VPN2_W-1:0] r_vpn2;
  logic              r_odd;
  logic [31:0]       r_even_addr;
  logic [IDX_W-1:0]  r_victim;
  logic [31:0]       r_lo0;
  logic [31:0]       r_entry_hi;
  logic [31:0]       r_entry_lo0;
  logic [31:0]       r_entry_lo1;
  logic [31:0]       r_index;
  logic [IDX_W-1:0]  w_victim;
  logic              w_accept;
  logic              w_unmapped;
  logic [31:0]       w_sel_pte;
  logic              w_sel_valid;
  logic              w_unused_vaddr_lo;

  tlb_victim_ctr #(
    .ENTRIES (ENTRIES),
    .WIRED   (WIRED),
    .IDX_W   (IDX_W)
  ) u_victim (
    .clock    (clock),
    .reset    (reset),
    .o_victim (w_victim)
  );

  assign w_accept    = miss_valid && (r_state == ST_IDLE);
  assign w_unmapped  = (miss_vaddr[31:30] == KSEG_UNMAPPED);
  // The odd PTE is only ever examined in the cycle it arrives on mem_rdata.
  assign w_sel_pte   = r_odd ? mem_rdata : r_lo0;
  assign w_sel_valid = w_sel_pte[V_BIT];
  // Page-offset bits below the odd/even selector play no part in a walk.
  assign w_unused_vaddr_lo = ^miss_vaddr[ODD_SEL_BIT-1:0];

  always_ff @(posedge clock) begin
    if (!reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_next = w_unmapped ? ST_FAULT : ST_RD_EVEN;
      ST_RD_EVEN: if (mem_ack)  w_next = ST_RD_ODD;
      ST_RD_ODD:  if (mem_ack)  w_next = w_sel_valid ? ST_WRITE : ST_FAULT;
      ST_WRITE:   w_next = ST_IDLE;
      ST_FAULT:   w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    miss_ready = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = 32'd0;
    tlb_we     = 1'b0;
    done       = 1'b0;
    fault      = 1'b0;
    case (r_state)
      ST_IDLE:    miss_ready = 1'b1;
      ST_RD_EVEN: begin
        mem_req  = 1'b1;
        mem_addr = r_even_addr;
      end
      ST_RD_ODD:  begin
        mem_req  = 1'b1;
        mem_addr = r_even_addr + 32'd4;
      end
      ST_WRITE:   begin
        tlb_we = 1'b1;
        done   = 1'b1;
      end
      ST_FAULT:   begin
        done  = 1'b1;
        fault = 1'b1;
      end
      default:    ;
    endcase
  end

  // Walk context is captured at accept; the TLB-facing registers are only
  // loaded on the edge into WRITE, so they hold across faults and idle time.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_vpn2      <= '0;
      r_odd       <= 1'b0;
      r_even_addr <= 32'd0;
      r_victim    <= '0;
      r_lo0       <= 32'd0;
      r_entry_hi  <= 32'd0;
      r_entry_lo0 <= 32'd0;
      r_entry_lo1 <= 32'd0;
      r_index     <= 32'd0;
    end else begin
      if (w_accept) begin
        r_vpn2      <= miss_vaddr[VPN2_HI:VPN2_LO];
        r_odd       <= miss_vaddr[ODD_SEL_BIT];
        r_even_addr <= pte_pair_addr(ptbase, miss_vaddr[VPN2_HI:VPN2_LO]);
        r_victim    <= w_victim;
      end
      if ((r_state == ST_RD_EVEN) && mem_ack)
        r_lo0 <= mem_rdata;
      if ((r_state == ST_RD_ODD) && mem_ack && w_sel_valid) begin
        r_entry_hi  <= {r_vpn2, {VPN2_LO{1'b0}}};
        r_entry_lo0 <= r_lo0;
        r_entry_lo1 <= mem_rdata;
        r_index     <= {{(32 - IDX_W){1'b0}}, r_victim};
      end
    end
  end

  assign tlb_entry_hi  = r_entry_hi;
  assign tlb_entry_lo0 = r_entry_lo0;
  assign tlb_entry_lo1 = r_entry_lo1;
  assign tlb_index     = r_index;

`ifdef TLB_WALK_STATS_EN
  logic [31:0] r_walk_count;
  logic [31:0] r_fault_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_walk_count  <= 32'd0;
      r_fault_count <= 32'd0;
    end else begin
      if (w_accept && (r_walk_count != 32'hFFFF_FFFF))
        r_walk_count <= r_walk_count + 32'd1;
      if ((r_state == ST_FAULT) && (r_fault_count != 32'hFFFF_FFFF))
        r_fault_count <= r_fault_count + 32'd1;
    end
  end

  assign walk_count  = r_walk_count;
  assign fault_count = r_fault_count;
`endif

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Testbench for tlb_refill_walker (built with WIRED=2).
module tb_tlb_refill_walker;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
  localparam int WIRED   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        miss_valid = 1'b0;
  logic [31:0] miss_vaddr = 32'd0;
  logic        miss_ready;
  logic [31:0] ptbase = 32'd0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        tlb_we;
  logic [31:0] tlb_index;
  logic [31:0] tlb_entry_hi;
  logic [31:0] tlb_entry_lo0;
  logic [31:0] tlb_entry_lo1;
  logic        done;
  logic        fault;
`ifdef TLB_WALK_STATS_EN
  logic [31:0] walk_count;
  logic [31:0] fault_count;
`endif

  int errors = 0;
  int checks = 0;
  int n_edges = 0;

  tlb_refill_walker #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .WIRED   (WIRED)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .miss_valid    (miss_valid),
    .miss_vaddr    (miss_vaddr),
    .miss_ready    (miss_ready),
    .ptbase        (ptbase),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .tlb_we        (tlb_we),
    .tlb_index     (tlb_index),
    .tlb_entry_hi  (tlb_entry_hi),
    .tlb_entry_lo0 (tlb_entry_lo0),
    .tlb_entry_lo1 (tlb_entry_lo1),
    .done          (done),
    .fault         (fault)
`ifdef TLB_WALK_STATS_EN
    ,
    .walk_count    (walk_count),
    .fault_count   (fault_count)
`endif
  );

  always #5 clock = ~clock;

  // Clock edges seen since the last reset edge; the victim offered at an
  // accept is WIRED plus this count modulo the replaceable range.
  always @(posedge clock) begin
    if (!reset) n_edges <= 0;
    else        n_edges <= n_edges + 1;
  end

  typedef struct packed {
    logic [31:0]      a0;
    logic [31:0]      a1;
    logic             stable;
    logic             rdy_low;
    logic             anyreq;
    logic             timeout;
    logic             we;
    logic             flt;
    logic             post_req;
    logic             post_done;
    logic [7:0]       nreads;
    logic [7:0]       lat;
    logic [31:0]      hi;
    logic [31:0]      l0;
    logic [31:0]      l1;
    logic [31:0]      idx;
    logic [IDX_W-1:0] exp_vic;
  } walk_obs_t;

  function automatic logic [31:0] exp_even(input logic [31:0] base, input logic [31:0] va);
    return base + ((va >> 13) << 3);
  endfunction

  // Drives one miss, plays a memory with waitc wait cycles per read, and
  // records what the walker did. Comparisons live in the calling tests.
  task automatic do_walk(input logic [31:0] va, input logic [31:0] pe, input logic [31:0] po,
                         input int waitc, input bit poke, input bit noise,
                         output walk_obs_t o);
    int cyc;
    int w;
    int r;
    bit seen;
    o = '0;
    o.a0 = 32'hFFFF_FFFF;
    o.a1 = 32'hFFFF_FFFF;
    o.stable = 1'b1;
    o.rdy_low = 1'b1;
    @(negedge clock);
    o.exp_vic = IDX_W'(WIRED + (n_edges % (ENTRIES - WIRED)));
    mem_ack = 1'b0;
    miss_valid = 1'b1;
    miss_vaddr = va;
    cyc = 0; w = 0; r = 0; seen = 0;
    while (!seen && cyc < 80) begin
      @(negedge clock);
      cyc++;
      miss_valid = poke;
      if (poke) miss_vaddr = ~va;
      mem_ack = 1'b0;
      if (miss_ready) o.rdy_low = 1'b0;
      if (mem_req) begin
        o.anyreq = 1'b1;
        if (r == 0) begin
          if (w == 0) o.a0 = mem_addr;
          else if (mem_addr !== o.a0) o.stable = 1'b0;
        end else if (r == 1) begin
          if (w == 0) o.a1 = mem_addr;
          else if (mem_addr !== o.a1) o.stable = 1'b0;
        end
        if (w >= waitc) begin
          mem_ack = 1'b1;
          mem_rdata = (r == 0) ? pe : po;
          o.nreads = o.nreads + 8'd1;
          r++;
          w = 0;
        end else begin
          w++;
        end
      end else if (noise) begin
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = $urandom();
      end
      if (done) begin
        seen = 1;
        o.lat = 8'(cyc);
        o.we = tlb_we;
        o.flt = fault;
        o.hi = tlb_entry_hi;
        o.l0 = tlb_entry_lo0;
        o.l1 = tlb_entry_lo1;
        o.idx = tlb_index;
        miss_valid = 1'b0;
      end
    end
    o.timeout = !seen;
    miss_valid = 1'b0;
    @(negedge clock);
    mem_ack = 1'b0;
    o.post_req = mem_req;
    o.post_done = done | tlb_we;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (miss_ready !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 32'd0 ||
        tlb_we !== 1'b0 || done !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b req=%b addr=%h we=%b done=%b fault=%b required 1 0 0 0 0 0",
               miss_ready, mem_req, mem_addr, tlb_we, done, fault);
    end
    checks++;
    if (tlb_index !== 32'd0 || tlb_entry_hi !== 32'd0 || tlb_entry_lo0 !== 32'd0 || tlb_entry_lo1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_entries: idx=%h hi=%h lo0=%h lo1=%h required all 0",
               tlb_index, tlb_entry_hi, tlb_entry_lo0, tlb_entry_lo1);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (miss_ready !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b req=%b required 1 0", miss_ready, mem_req);
    end
  endtask

  task automatic test_happy_path;
    walk_obs_t o;
    logic [31:0] va;
    va = 32'h0040_2ABC;
    ptbase = 32'h0010_0000;
    do_walk(va, 32'h0000_0046, 32'h0000_0086, 0, 0, 0, o);
    checks++;
    if (o.a0 !== exp_even(ptbase, va) || o.a1 !== exp_even(ptbase, va) + 32'd4) begin
      errors++;
      $display("FAIL happy_addr: a0=%h a1=%h required %h %h", o.a0, o.a1,
               exp_even(ptbase, va), exp_even(ptbase, va) + 32'd4);
    end
    checks++;
    if (o.timeout || o.we !== 1'b1 || o.flt !== 1'b0 || o.lat !== 8'd3) begin
      errors++;
      $display("FAIL happy_strobe: timeout=%b we=%b fault=%b lat=%0d required 0 1 0 3",
               o.timeout, o.we, o.flt, o.lat);
    end
    checks++;
    if (o.hi !== 32'h0040_2000 || o.l0 !== 32'h0000_0046 || o.l1 !== 32'h0000_0086) begin
      errors++;
      $display("FAIL happy_entries: hi=%h lo0=%h lo1=%h required 00402000 00000046 00000086",
               o.hi, o.l0, o.l1);
    end
    checks++;
    if (o.idx !== {28'd0, o.exp_vic}) begin
      errors++;
      $display("FAIL happy_index: idx=%h required %h", o.idx, {28'd0, o.exp_vic});
    end
    checks++;
    if (o.post_req !== 1'b0 || o.post_done !== 1'b0 || tlb_entry_hi !== 32'h0040_2000) begin
      errors++;
      $display("FAIL happy_after: req=%b done=%b hi=%h required 0 0 00402000",
               o.post_req, o.post_done, tlb_entry_hi);
    end
  endtask

  task automatic test_invalid_pte;
    walk_obs_t o;
    do_walk(32'h0060_3000, 32'h0000_0046, 32'h0000_0080, 0, 0, 0, o);
    checks++;
    if (o.timeout || o.flt !== 1'b1 || o.we !== 1'b0 || o.nreads !== 8'd2) begin
      errors++;
      $display("FAIL invalid_pte: timeout=%b fault=%b we=%b reads=%0d required 0 1 0 2",
               o.timeout, o.flt, o.we, o.nreads);
    end
    checks++;
    if (o.post_req !== 1'b0 || o.hi !== 32'h0040_2000 || o.l1 !== 32'h0000_0086) begin
      errors++;
      $display("FAIL invalid_hold: req=%b hi=%h lo1=%h required 0 00402000 00000086",
               o.post_req, o.hi, o.l1);
    end
  endtask

  task automatic test_unmapped;
    walk_obs_t o;
    do_walk(32'h8000_1000, 32'h0000_0046, 32'h0000_0086, 0, 0, 0, o);
    checks++;
    if (o.timeout || o.flt !== 1'b1 || o.we !== 1'b0 || o.lat !== 8'd1) begin
      errors++;
      $display("FAIL unmapped: timeout=%b fault=%b we=%b lat=%0d required 0 1 0 1",
               o.timeout, o.flt, o.we, o.lat);
    end
    checks++;
    if (o.anyreq !== 1'b0 || o.post_req !== 1'b0) begin
      errors++;
      $display("FAIL unmapped_noreq: anyreq=%b post=%b required 0 0", o.anyreq, o.post_req);
    end
  endtask

  task automatic test_wait_states;
    walk_obs_t o;
    logic [31:0] va;
    va = 32'h1234_5678;
    ptbase = 32'h0200_0008;
    do_walk(va, 32'h0ABC_DE47, 32'h0123_4503, 5, 1, 0, o);
    checks++;
    if (o.stable !== 1'b1 || o.rdy_low !== 1'b1 || o.nreads !== 8'd2) begin
      errors++;
      $display("FAIL wait_stable: stable=%b ready_low=%b reads=%0d required 1 1 2",
               o.stable, o.rdy_low, o.nreads);
    end
    checks++;
    if (o.a0 !== exp_even(ptbase, va) || o.a1 !== exp_even(ptbase, va) + 32'd4) begin
      errors++;
      $display("FAIL wait_addr: a0=%h a1=%h required %h %h", o.a0, o.a1,
               exp_even(ptbase, va), exp_even(ptbase, va) + 32'd4);
    end
    checks++;
    if (o.timeout || o.lat !== 8'd13 || o.we !== 1'b1 || o.hi !== (va & 32'hFFFF_E000)) begin
      errors++;
      $display("FAIL wait_result: timeout=%b lat=%0d we=%b hi=%h required 0 13 1 %h",
               o.timeout, o.lat, o.we, o.hi, va & 32'hFFFF_E000);
    end
    checks++;
    if (o.post_req !== 1'b0 || miss_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ignored_miss: req=%b ready=%b required 0 1", o.post_req, miss_ready);
    end
  endtask

  task automatic test_random;
    walk_obs_t o;
    logic [31:0] va;
    logic [31:0] pe;
    logic [31:0] po;
    logic [31:0] sel;
    bit unm;
    bit flt;
    for (int k = 0; k < 24; k++) begin
      ptbase = (k % 5 == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFF8);
      va = $urandom();
      if (k % 4 == 0) va[31:30] = 2'b10;
      else if (va[31:30] == 2'b10) va[31] = 1'b0;
      pe = $urandom();
      po = $urandom();
      do_walk(va, pe, po, int'($urandom_range(0, 3)), 0, 1, o);
      unm = (va[31:30] == 2'b10);
      sel = va[12] ? po : pe;
      flt = unm || !sel[1];
      checks++;
      if (o.timeout || o.flt !== flt || o.we !== !flt || o.post_req !== 1'b0) begin
        errors++;
        $display("FAIL rand_outcome[%0d]: timeout=%b fault=%b we=%b post=%b required 0 %b %b 0",
                 k, o.timeout, o.flt, o.we, o.post_req, flt, !flt);
      end
      checks++;
      if (unm ? (o.nreads !== 8'd0) :
          (o.nreads !== 8'd2 || o.a0 !== exp_even(ptbase, va) || o.a1 !== exp_even(ptbase, va) + 32'd4)) begin
        errors++;
        $display("FAIL rand_reads[%0d]: reads=%0d a0=%h a1=%h required %0d %h %h", k, o.nreads,
                 o.a0, o.a1, unm ? 0 : 2, exp_even(ptbase, va), exp_even(ptbase, va) + 32'd4);
      end
      if (!flt) begin
        checks++;
        if (o.hi !== (va & 32'hFFFF_E000) || o.l0 !== pe || o.l1 !== po || o.idx !== {28'd0, o.exp_vic}) begin
          errors++;
          $display("FAIL rand_entry[%0d]: hi=%h lo0=%h lo1=%h idx=%h required %h %h %h %h", k,
                   o.hi, o.l0, o.l1, o.idx, va & 32'hFFFF_E000, pe, po, {28'd0, o.exp_vic});
        end
      end
    end
  endtask

  task automatic test_victim_wrap;
    walk_obs_t o;
    logic [31:0] prev;
    int wraps;
    bit in_range;
    prev = 32'd0;
    wraps = 0;
    in_range = 1;
    ptbase = 32'h0001_0000;
    for (int k = 0; k < 20; k++) begin
      do_walk({$urandom()} & 32'h7FFF_FFFF, 32'h0000_0002, 32'h0000_0002, 0, 0, 0, o);
      checks++;
      if (o.timeout || o.we !== 1'b1 || o.idx !== {28'd0, o.exp_vic}) begin
        errors++;
        $display("FAIL victim[%0d]: timeout=%b we=%b idx=%0d required 0 1 %0d",
                 k, o.timeout, o.we, o.idx, o.exp_vic);
      end
      if (o.idx < 32'd2 || o.idx > 32'd15) in_range = 0;
      if (k > 0 && o.idx < prev) wraps++;
      prev = o.idx;
    end
    checks++;
    if (!in_range || wraps == 0) begin
      errors++;
      $display("FAIL victim_range: in_range=%b wraps=%0d required 1 >0", in_range, wraps);
    end
  endtask

  task automatic test_reset_midwalk;
    walk_obs_t o;
    logic [31:0] va;
    bit bad;
    int guard;
    va = 32'h0070_1000;
    ptbase = 32'h0030_0000;
    @(negedge clock);
    miss_valid = 1'b1;
    miss_vaddr = va;
    @(negedge clock);
    miss_valid = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h0000_0042;
    @(negedge clock);
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== exp_even(ptbase, va) + 32'd4) begin
      errors++;
      $display("FAIL midwalk_rdodd: req=%b addr=%h required 1 %h",
               mem_req, mem_addr, exp_even(ptbase, va) + 32'd4);
    end
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    checks++;
    if (mem_req !== 1'b0 || miss_ready !== 1'b1 || tlb_we !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midwalk_reset: req=%b ready=%b we=%b done=%b required 0 1 0 0",
               mem_req, miss_ready, tlb_we, done);
    end
    bad = 0;
    guard = 0;
    repeat (4) begin
      @(negedge clock);
      guard++;
      if (tlb_we || done || mem_req) bad = 1;
    end
    checks++;
    if (bad || guard != 4) begin
      errors++;
      $display("FAIL midwalk_quiet: activity=%b required 0", bad);
    end
    do_walk(va, 32'h0000_0042, 32'h0000_0006, 0, 0, 0, o);
    checks++;
    if (o.timeout || o.we !== 1'b1 || o.lat !== 8'd3 || o.l1 !== 32'h0000_0006 ||
        o.idx !== {28'd0, o.exp_vic}) begin
      errors++;
      $display("FAIL midwalk_after: timeout=%b we=%b lat=%0d lo1=%h idx=%0d required 0 1 3 00000006 %0d",
               o.timeout, o.we, o.lat, o.l1, o.idx, o.exp_vic);
    end
  endtask

  initial begin
    test_reset();
    test_happy_path();
    test_invalid_pte();
    test_unmapped();
    test_wait_states();
    test_random();
    test_victim_wrap();
    test_reset_midwalk();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
